// File: rtl/sram_port0_ctrl.sv
// Port-0 (RW) request/response front end for the 32x512 1RW1R OpenRAM macro.
// Registers the macro's port-0 inputs, captures dout0 two cycles after a read issue, buffers reads in a 4-deep FIFO.
module sram_port0_ctrl #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WMASKS = 4,
  parameter bit INIT_ZERO  = 1'b1
) (
  input  logic                  clk,
  input  logic                  resetb,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [NUM_WMASKS-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [NUM_WMASKS-1:0] sram_wmask0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] init_addr_q, init_addr_d;
  logic [1:0]            rd_pipe_q;
  logic [DATA_WIDTH-1:0] fifo_mem_q [FIFO_DEPTH];
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic [2:0]            count_q;
  logic [2:0]            credits_used;
  logic                  accept, accept_rd, push, pop;

  logic                  csb_d, web_d;
  logic [NUM_WMASKS-1:0] wmask_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DATA_WIDTH-1:0] din_d;

  // Credits come from registered state only, so a pop in this cycle frees its slot one cycle later.
  always_comb begin
    credits_used = count_q + 3'(rd_pipe_q[0]) + 3'(rd_pipe_q[1]);
    req_ready    = init_done && (req_we || (credits_used < 3'(FIFO_DEPTH)));
    accept       = req_valid && req_ready;
    accept_rd    = accept && !req_we;
    push         = rd_pipe_q[1];
    rsp_valid    = (count_q != 3'd0);
    pop          = rsp_valid && rsp_ready;
    rsp_rdata    = fifo_mem_q[rd_ptr_q];
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned and infers a latch.
  always_comb begin
    state_d     = state_q;
    init_addr_d = init_addr_q;
    csb_d       = 1'b1;
    web_d       = sram_web0;
    wmask_d     = sram_wmask0;
    addr_d      = sram_addr0;
    din_d       = sram_din0;
    unique case (state_q)
      S_INIT: begin
        csb_d       = 1'b0;
        web_d       = 1'b0;
        wmask_d     = '1;
        addr_d      = init_addr_q;
        din_d       = '0;
        init_addr_d = init_addr_q + 1'b1;
        if (&init_addr_q) state_d = S_RUN;
      end
      S_RUN: begin
        if (accept) begin
          csb_d   = 1'b0;
          web_d   = ~req_we;
          wmask_d = req_we ? req_wmask : '0;
          addr_d  = req_addr;
          din_d   = req_wdata;
        end
      end
      default: state_d = S_RUN;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_q     <= INIT_ZERO ? S_INIT : S_RUN;
      init_addr_q <= '0;
      init_done   <= 1'b0;
      sram_csb0   <= 1'b1;
      sram_web0   <= 1'b1;
      sram_wmask0 <= '0;
      sram_addr0  <= '0;
      sram_din0   <= '0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      init_addr_q <= init_addr_d;
      init_done   <= (state_d == S_RUN);
      sram_csb0   <= csb_d;
      sram_web0   <= web_d;
      sram_wmask0 <= wmask_d;
      sram_addr0  <= addr_d;
      sram_din0   <= din_d;
      rd_pipe_q   <= {rd_pipe_q[0], accept_rd};
    end
  end

  // NOTE: the FIFO storage is reset because its head drives rsp_rdata, which must read zero out of reset.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_mem_q[wr_ptr_q] <= sram_dout0;
        wr_ptr_q             <= wr_ptr_q + 2'd1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 3'd1;
        2'b01:   count_q <= count_q - 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_port0_ctrl.sv
// Self-checking bench for sram_port0_ctrl with a behavioural model of the OpenRAM port-0 macro.
// Directed vector table plus hand sequences for latency, backpressure, streaming and mid-operation reset.
module tb_sram_port0_ctrl;

  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int NW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          resetb;
  logic          req_valid, req_ready, req_we;
  logic [NW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          init_done;
  logic          sram_csb0, sram_web0;
  logic [NW-1:0] sram_wmask0;
  logic [AW-1:0] sram_addr0;
  logic [DW-1:0] sram_din0;
  logic [DW-1:0] sram_dout0;

  always #5 clk = ~clk;

  sram_port0_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_WMASKS(NW), .INIT_ZERO(1'b1)
  ) dut (
    .clk(clk), .resetb(resetb),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .init_done(init_done),
    .sram_csb0(sram_csb0), .sram_web0(sram_web0), .sram_wmask0(sram_wmask0),
    .sram_addr0(sram_addr0), .sram_din0(sram_din0), .sram_dout0(sram_dout0)
  );

  // Macro model: latches port-0 inputs on posedge, performs the access on the following negedge.
  logic [DW-1:0] mem [DEPTH];
  logic          m_csb, m_web;
  logic [NW-1:0] m_wmask;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_din;

  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    sram_dout0 = '0;
    m_csb = 1'b1; m_web = 1'b1; m_wmask = '0; m_addr = '0; m_din = '0;
    forever begin
      @(posedge clk);
      m_csb = sram_csb0; m_web = sram_web0; m_wmask = sram_wmask0;
      m_addr = sram_addr0; m_din = sram_din0;
      @(negedge clk);
      if (!m_csb) begin
        if (!m_web) begin
          for (int b = 0; b < NW; b++)
            if (m_wmask[b]) mem[m_addr][b*8 +: 8] = m_din[b*8 +: 8];
        end else begin
          sram_dout0 = mem[m_addr];
        end
      end
    end
  end

  // Event monitor: read-accept cycles and popped responses.
  int            cyc = 0;
  int            acc_cyc[$];
  int            pop_cyc[$];
  logic [DW-1:0] pop_data[$];

  always @(posedge clk) begin
    if (resetb) begin
      if (req_valid && req_ready && !req_we) acc_cyc.push_back(cyc);
      if (rsp_valid && rsp_ready) begin
        pop_data.push_back(rsp_rdata);
        pop_cyc.push_back(cyc);
      end
    end
    cyc <= cyc + 1;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
    check({tag, "_init_done"},   32'(init_done),   32'd0);
    check({tag, "_rsp_rdata"},   rsp_rdata,        32'd0);
    check({tag, "_csb0"},        32'(sram_csb0),   32'd1);
    check({tag, "_web0"},        32'(sram_web0),   32'd1);
    check({tag, "_wmask0"},      32'(sram_wmask0), 32'd0);
    check({tag, "_addr0"},       32'(sram_addr0),  32'd0);
    check({tag, "_din0"},        sram_din0,        32'd0);
  endtask

  task automatic send(input logic we, input logic [NW-1:0] wm, input logic [AW-1:0] a,
                      input logic [DW-1:0] d);
    int n = 0;
    req_valid = 1'b1; req_we = we; req_wmask = wm; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles at addr 0x%03h, required high", n, a);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_pops(input int target);
    int k = 0;
    while (pop_data.size() < target && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("pop_count", 32'(pop_data.size()), 32'(target));
  endtask

  typedef struct {
    logic          we;
    logic [NW-1:0] wmask;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] exp;
  } vec_t;

  vec_t vecs[13];

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded 20000 cycles, required completion");
    $fatal(1);
  end

  initial begin
    int            bad;
    int            base_acc, base_pop;
    logic [DW-1:0] exp_q[$];

    vecs[0]  = '{1'b0, 4'h0, 9'h005, 32'h0000_0000, 32'h0000_0000};
    vecs[1]  = '{1'b1, 4'hF, 9'h1A3, 32'hDEAD_BEEF, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 9'h1A3, 32'h0000_0000, 32'hDEAD_BEEF};
    vecs[3]  = '{1'b1, 4'h5, 9'h1A3, 32'h1122_3344, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 9'h1A3, 32'h0000_0000, 32'hDE22_BE44};
    vecs[5]  = '{1'b1, 4'hF, 9'h000, 32'hA5A5_A5A5, 32'h0};
    vecs[6]  = '{1'b1, 4'hF, 9'h1FF, 32'h5A5A_5A5A, 32'h0};
    vecs[7]  = '{1'b0, 4'h0, 9'h1FF, 32'h0000_0000, 32'h5A5A_5A5A};
    vecs[8]  = '{1'b0, 4'h0, 9'h000, 32'h0000_0000, 32'hA5A5_A5A5};
    vecs[9]  = '{1'b1, 4'h8, 9'h1FF, 32'hFFFF_FFFF, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 9'h1FF, 32'h0000_0000, 32'hFF5A_5A5A};
    vecs[11] = '{1'b1, 4'h0, 9'h010, 32'h1234_5678, 32'h0};
    vecs[12] = '{1'b0, 4'h0, 9'h010, 32'h0000_0000, 32'h0000_0000};

    req_valid = 1'b0; req_we = 1'b0; req_wmask = '0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b1; resetb = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");

    // Zeroing sweep: one write per cycle over the whole array.
    @(negedge clk);
    resetb = 1'b1;
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      if (sram_csb0 !== 1'b0 || sram_web0 !== 1'b0 || sram_addr0 !== AW'(i) ||
          sram_wmask0 !== 4'hF || sram_din0 !== 32'd0) bad++;
      if (i < DEPTH - 1 && (req_ready !== 1'b0 || init_done !== 1'b0)) bad++;
    end
    check("init_seq_errors", 32'(bad), 32'd0);
    check("init_done_high", 32'(init_done), 32'd1);
    check("ready_after_init", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    check("csb_idle_after_init", 32'(sram_csb0), 32'd1);

    // Table vectors, issued back to back.
    base_acc = acc_cyc.size();
    base_pop = pop_data.size();
    for (int v = 0; v < 13; v++) begin
      send(vecs[v].we, vecs[v].wmask, vecs[v].addr, vecs[v].wdata);
      if (!vecs[v].we) exp_q.push_back(vecs[v].exp);
    end
    wait_pops(base_pop + exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) begin
      if (base_pop + k < pop_data.size()) begin
        check($sformatf("vec_rdata_%0d", k), pop_data[base_pop + k], exp_q[k]);
        check($sformatf("vec_latency_%0d", k),
              32'(pop_cyc[base_pop + k] - acc_cyc[base_acc + k]), 32'd3);
      end
    end

    // Write then read the next cycle: issued port values and exact response timing.
    send(1'b1, 4'hF, 9'h0AB, 32'hCAFE_F00D);
    check("wr_issue_csb", 32'(sram_csb0), 32'd0);
    check("wr_issue_web", 32'(sram_web0), 32'd0);
    check("wr_issue_addr", 32'(sram_addr0), 32'h0AB);
    check("wr_issue_din", sram_din0, 32'hCAFE_F00D);
    send(1'b0, 4'hF, 9'h0AB, 32'h0);
    check("rd_issue_web", 32'(sram_web0), 32'd1);
    check("rd_issue_wmask", 32'(sram_wmask0), 32'd0);
    check("rd_valid_t0", 32'(rsp_valid), 32'd0);
    @(posedge clk); #1;
    check("rd_valid_t1", 32'(rsp_valid), 32'd0);
    check("csb_idle_t1", 32'(sram_csb0), 32'd1);
    @(posedge clk); #1;
    check("rd_valid_t2", 32'(rsp_valid), 32'd1);
    check("rd_data_t2", rsp_rdata, 32'hCAFE_F00D);
    @(posedge clk); #1;

    // Backpressure: only four reads fit while the consumer stalls.
    for (int i = 0; i < 6; i++) send(1'b1, 4'hF, AW'(i), 32'hB0B0_0000 | 32'(i));
    base_acc = acc_cyc.size();
    base_pop = pop_data.size();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(1'b0, 4'h0, AW'(i), 32'h0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = AW'(4);
    repeat (8) @(posedge clk);
    #1;
    check("bp_ready_low", 32'(req_ready), 32'd0);
    check("bp_accepts", 32'(acc_cyc.size() - base_acc), 32'd4);
    check("bp_head_valid", 32'(rsp_valid), 32'd1);
    check("bp_head_data", rsp_rdata, 32'hB0B0_0000);
    rsp_ready = 1'b1;
    send(1'b0, 4'h0, AW'(4), 32'h0);
    send(1'b0, 4'h0, AW'(5), 32'h0);
    wait_pops(base_pop + 6);
    check("bp_accepts_total", 32'(acc_cyc.size() - base_acc), 32'd6);
    for (int i = 0; i < 6; i++)
      if (base_pop + i < pop_data.size())
        check($sformatf("bp_rdata_%0d", i), pop_data[base_pop + i], 32'hB0B0_0000 | 32'(i));

    // Streaming: 16 reads back to back with the consumer always ready.
    for (int i = 0; i < 16; i++) send(1'b1, 4'hF, AW'(9'h100 + i), 32'h5700_0000 + 32'(i));
    base_acc = acc_cyc.size();
    base_pop = pop_data.size();
    for (int i = 0; i < 16; i++) send(1'b0, 4'h0, AW'(9'h100 + i), 32'h0);
    wait_pops(base_pop + 16);
    check("stream_accept_span", 32'(acc_cyc[base_acc + 15] - acc_cyc[base_acc]), 32'd15);
    if (pop_data.size() >= base_pop + 16) begin
      check("stream_pop_span", 32'(pop_cyc[base_pop + 15] - pop_cyc[base_pop]), 32'd15);
      bad = 0;
      for (int i = 0; i < 16; i++)
        if (pop_data[base_pop + i] !== 32'h5700_0000 + 32'(i)) bad++;
      check("stream_data_errors", 32'(bad), 32'd0);
    end

    // Reset with three reads in flight.
    base_pop = pop_data.size();
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(1'b0, 4'h0, AW'(9'h100 + i), 32'h0);
    resetb = 1'b0;
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    resetb = 1'b1;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (sram_addr0 !== AW'(i) || sram_csb0 !== 1'b0 || sram_web0 !== 1'b0) bad++;
      if (rsp_valid !== 1'b0 || init_done !== 1'b0) bad++;
    end
    check("reinit_seq_errors", 32'(bad), 32'd0);
    check("no_stale_pops", 32'(pop_data.size()), 32'(base_pop));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
